// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and FSM state type for the instruction fetch stage
package if_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

`ifdef IF_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;
`endif

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with enable, stall, flush and bubble insertion
module if_id_reg
    import if_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            stall,
    input  logic            flush,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_inst,
    input  logic            load_misalign,
    output logic [XLEN-1:0] pc_id,
    output logic [XLEN-1:0] inst_id,
    output logic            valid_id,
    output logic            misalign_id
);

    // A flush or bubble keeps pc_id so the last real PC stays visible downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_id       <= '0;
            inst_id     <= NOP;
            valid_id    <= 1'b0;
            misalign_id <= 1'b0;
        end else if (flush) begin
            inst_id     <= NOP;
            valid_id    <= 1'b0;
            misalign_id <= 1'b0;
        end else if (en && !stall) begin
            if (load_valid) begin
                pc_id       <= load_pc;
                inst_id     <= load_inst;
                valid_id    <= 1'b1;
                misalign_id <= load_misalign;
            end else begin
                inst_id     <= NOP;
                valid_id    <= 1'b0;
                misalign_id <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - fetch FSM and PC; IF_MISALIGN_CHECK_EN enables misaligned-target HALT handling
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_EN_IF,
    input  logic        reg_FD_EN,
    input  logic        reg_FD_stall,
    input  logic        reg_FD_flush,
    input  logic        branch_taken_ID,
    input  logic [31:0] branch_target_ID,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_ID,
    output logic [31:0] inst_ID,
    output logic        valid_ID,
    output logic        fetch_busy,
    output logic        misalign_ID
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] hold_inst;
    logic            advance;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] drop_pc;
    fetch_state_t    tgt_state;
    fetch_state_t    drop_state;
    logic            load_valid;
    logic [XLEN-1:0] load_inst;
    logic            load_misalign;

    assign advance    = reg_FD_EN & PC_EN_IF & ~reg_FD_stall;
    assign drop_pc    = branch_taken_ID ? tgt : pc;
    assign imem_req   = (state == FETCH) || (state == DROP);
    assign imem_addr  = addr_q;
    assign fetch_busy = imem_req;

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_pend;
    logic tgt_mis;
    logic drop_mis;

    assign tgt        = branch_target_ID;
    assign tgt_mis    = |branch_target_ID[1:0];
    assign drop_mis   = |drop_pc[1:0];
    assign tgt_state  = tgt_mis ? HALT : FETCH;
    assign drop_state = drop_mis ? HALT : FETCH;

    // Remembers that the misaligned target still owes one record to IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_pend <= 1'b0;
        end else if (branch_taken_ID && state != DROP) begin
            misalign_pend <= tgt_mis;
        end else if (state == DROP && imem_ack) begin
            misalign_pend <= drop_mis;
        end else if (state == HALT && advance) begin
            misalign_pend <= 1'b0;
        end
    end
`else
    assign tgt        = branch_target_ID & 32'hFFFF_FFFC;
    assign tgt_state  = FETCH;
    assign drop_state = FETCH;
`endif

    always_comb begin
        load_valid    = 1'b0;
        load_inst     = imem_rdata;
        load_misalign = 1'b0;
        if (advance && !branch_taken_ID) begin
            case (state)
                FETCH: load_valid = imem_ack;
                HOLD: begin
                    load_valid = 1'b1;
                    load_inst  = hold_inst;
                end
`ifdef IF_MISALIGN_CHECK_EN
                HALT: begin
                    load_valid    = misalign_pend;
                    load_inst     = NOP;
                    load_misalign = misalign_pend;
                end
`endif
                default: load_valid = 1'b0;
            endcase
        end
    end

    // Redirects win over responses; in DROP the stale address stays on the bus until acked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            addr_q    <= RESET_PC;
            hold_inst <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (branch_taken_ID) begin
                        pc <= tgt;
                        if (imem_ack) begin
                            addr_q <= tgt;
                            state  <= tgt_state;
                        end else begin
                            state <= DROP;
                        end
                    end else if (imem_ack) begin
                        if (advance) begin
                            pc     <= pc + 32'd4;
                            addr_q <= pc + 32'd4;
                        end else begin
                            hold_inst <= imem_rdata;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (branch_taken_ID) begin
                        pc     <= tgt;
                        addr_q <= tgt;
                        state  <= tgt_state;
                    end else if (advance) begin
                        pc     <= pc + 32'd4;
                        addr_q <= pc + 32'd4;
                        state  <= FETCH;
                    end
                end
                DROP: begin
                    pc <= drop_pc;
                    if (imem_ack) begin
                        addr_q <= drop_pc;
                        state  <= drop_state;
                    end
                end
`ifdef IF_MISALIGN_CHECK_EN
                HALT: begin
                    if (branch_taken_ID) begin
                        pc     <= tgt;
                        addr_q <= tgt;
                        state  <= tgt_state;
                    end
                end
`endif
                default: state <= FETCH;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .en           (reg_FD_EN),
        .stall        (reg_FD_stall),
        .flush        (reg_FD_flush),
        .load_valid   (load_valid),
        .load_pc      (pc),
        .load_inst    (load_inst),
        .load_misalign(load_misalign),
        .pc_id        (PC_ID),
        .inst_id      (inst_ID),
        .valid_id     (valid_ID),
        .misalign_id  (misalign_ID)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench: vector table, corner sequences, random run against a queue model
module tb_if_fetch_stage;

    localparam logic [31:0] NOP_I = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        PC_EN_IF;
    logic        reg_FD_EN;
    logic        reg_FD_stall;
    logic        reg_FD_flush;
    logic        branch_taken_ID;
    logic [31:0] branch_target_ID;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC_ID;
    logic [31:0] inst_ID;
    logic        valid_ID;
    logic        fetch_busy;
    logic        misalign_ID;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .PC_EN_IF        (PC_EN_IF),
        .reg_FD_EN       (reg_FD_EN),
        .reg_FD_stall    (reg_FD_stall),
        .reg_FD_flush    (reg_FD_flush),
        .branch_taken_ID (branch_taken_ID),
        .branch_target_ID(branch_target_ID),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .PC_ID           (PC_ID),
        .inst_ID         (inst_ID),
        .valid_ID        (valid_ID),
        .fetch_busy      (fetch_busy),
        .misalign_ID     (misalign_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic a, input logic e, input logic p, input logic s,
                         input logic f, input logic b, input logic [31:0] t);
        @(negedge clk);
        imem_ack         = a;
        reg_FD_EN        = e;
        PC_EN_IF         = p;
        reg_FD_stall     = s;
        reg_FD_flush     = f;
        branch_taken_ID  = b;
        branch_target_ID = t;
        imem_rdata       = a ? inst_of(imem_addr) : 32'hBAD0_BAD0;
    endtask

    typedef struct {
        logic        ack, en, pcen, stall, flush, br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr, pc_id, inst;
        logic        valid;
    } vec_t;

    function automatic vec_t mk(input logic a, input logic e, input logic p, input logic s,
                                input logic f, input logic b, input logic [31:0] t,
                                input logic rq, input logic [31:0] ad, input logic [31:0] pi,
                                input logic [31:0] in, input logic v);
        vec_t r;
        r.ack = a; r.en = e; r.pcen = p; r.stall = s; r.flush = f; r.br = b; r.tgt = t;
        r.req = rq; r.addr = ad; r.pc_id = pi; r.inst = in; r.valid = v;
        return r;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    vec_t tbl[23];
    ent_t fq[$];

    initial begin
        logic [31:0] m_pc, m_addr, m_id_pc, m_id_inst, gpc, ginst, t;
        logic        m_stale, m_id_valid, got, adv;
        logic        a, e, p, s, f, b;

        tbl[0]  = mk(1,1,1,0,0,0,0,            1,32'h0,  32'h0,  inst_of(32'h0),  1);
        tbl[1]  = mk(1,1,1,0,0,0,0,            1,32'h4,  32'h4,  inst_of(32'h4),  1);
        tbl[2]  = mk(1,1,1,0,0,0,0,            1,32'h8,  32'h8,  inst_of(32'h8),  1);
        tbl[3]  = mk(1,1,1,0,0,0,0,            1,32'hC,  32'hC,  inst_of(32'hC),  1);
        tbl[4]  = mk(0,1,1,0,0,0,0,            1,32'h10, 32'hC,  NOP_I,           0);
        tbl[5]  = mk(0,1,1,0,0,0,0,            1,32'h10, 32'hC,  NOP_I,           0);
        tbl[6]  = mk(0,1,1,0,0,0,0,            1,32'h10, 32'hC,  NOP_I,           0);
        tbl[7]  = mk(1,1,1,0,0,0,0,            1,32'h10, 32'h10, inst_of(32'h10), 1);
        tbl[8]  = mk(1,1,1,1,0,0,0,            1,32'h14, 32'h10, inst_of(32'h10), 1);
        tbl[9]  = mk(0,1,1,1,0,0,0,            0,32'h0,  32'h10, inst_of(32'h10), 1);
        tbl[10] = mk(0,1,1,0,0,0,0,            0,32'h0,  32'h14, inst_of(32'h14), 1);
        tbl[11] = mk(0,1,1,0,0,1,32'h100,      1,32'h18, 32'h14, NOP_I,           0);
        tbl[12] = mk(1,1,1,0,0,0,0,            1,32'h18, 32'h14, NOP_I,           0);
        tbl[13] = mk(1,1,1,0,0,0,0,            1,32'h100,32'h100,inst_of(32'h100),1);
        tbl[14] = mk(0,1,1,1,1,0,0,            1,32'h104,32'h100,NOP_I,           0);
        tbl[15] = mk(1,0,1,0,0,0,0,            1,32'h104,32'h100,NOP_I,           0);
        tbl[16] = mk(0,1,1,0,0,0,0,            0,32'h0,  32'h104,inst_of(32'h104),1);
        tbl[17] = mk(1,1,1,0,0,1,32'hFFFF_FFFC,1,32'h108,32'h104,NOP_I,           0);
        tbl[18] = mk(1,1,1,0,0,0,0,            1,32'hFFFF_FFFC,32'hFFFF_FFFC,inst_of(32'hFFFF_FFFC),1);
        tbl[19] = mk(1,1,1,0,0,0,0,            1,32'h0,  32'h0,  inst_of(32'h0),  1);
        tbl[20] = mk(1,1,1,1,0,0,0,            1,32'h4,  32'h0,  inst_of(32'h0),  1);
        tbl[21] = mk(0,1,1,0,0,1,32'h300,      0,32'h0,  32'h0,  NOP_I,           0);
        tbl[22] = mk(1,1,1,0,0,0,0,            1,32'h300,32'h300,inst_of(32'h300),1);

        rst = 1'b1;
        imem_ack = 0; reg_FD_EN = 1; PC_EN_IF = 1; reg_FD_stall = 0; reg_FD_flush = 0;
        branch_taken_ID = 0; branch_target_ID = 0; imem_rdata = 0;
        #1;
        chk("reset_valid", {31'b0, valid_ID}, 32'h0);
        chk("reset_inst", inst_ID, NOP_I);
        chk("reset_pc_id", PC_ID, 32'h0);
        chk("reset_misalign", {31'b0, misalign_ID}, 32'h0);
        chk("reset_addr", imem_addr, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].ack, tbl[i].en, tbl[i].pcen, tbl[i].stall, tbl[i].flush, tbl[i].br, tbl[i].tgt);
            #1;
            chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
            chk($sformatf("tbl%0d_busy", i), {31'b0, fetch_busy}, {31'b0, tbl[i].req});
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_pc_id", i), PC_ID, tbl[i].pc_id);
            chk($sformatf("tbl%0d_inst", i), inst_ID, tbl[i].inst);
            chk($sformatf("tbl%0d_valid", i), {31'b0, valid_ID}, {31'b0, tbl[i].valid});
            chk($sformatf("tbl%0d_mis", i), {31'b0, misalign_ID}, 32'h0);
        end

`ifdef IF_MISALIGN_CHECK_EN
        drive(1,1,1,0,0,1,32'h102);
        @(posedge clk); #1;
        chk("mis_redirect_bubble", {31'b0, valid_ID}, 32'h0);
        drive(0,1,1,0,0,0,0); #1;
        chk("mis_halt_req", {31'b0, imem_req}, 32'h0);
        @(posedge clk); #1;
        chk("mis_pc_id", PC_ID, 32'h102);
        chk("mis_inst", inst_ID, NOP_I);
        chk("mis_valid", {31'b0, valid_ID}, 32'h1);
        chk("mis_flag", {31'b0, misalign_ID}, 32'h1);
        drive(0,1,1,0,0,0,0); #1;
        chk("mis_halt_req2", {31'b0, imem_req}, 32'h0);
        @(posedge clk); #1;
        chk("mis_after_valid", {31'b0, valid_ID}, 32'h0);
        chk("mis_after_flag", {31'b0, misalign_ID}, 32'h0);
        drive(0,1,1,0,0,1,32'h200); #1;
        chk("mis_halt_req3", {31'b0, imem_req}, 32'h0);
        @(posedge clk);
        drive(1,1,1,0,0,0,0); #1;
        chk("mis_resume_req", {31'b0, imem_req}, 32'h1);
        chk("mis_resume_addr", imem_addr, 32'h200);
        @(posedge clk); #1;
        chk("mis_resume_pc_id", PC_ID, 32'h200);
        chk("mis_resume_inst", inst_ID, inst_of(32'h200));
`else
        drive(1,1,1,0,0,1,32'h102);
        @(posedge clk);
        drive(1,1,1,0,0,0,0); #1;
        chk("align_req", {31'b0, imem_req}, 32'h1);
        chk("align_addr", imem_addr, 32'h100);
        @(posedge clk); #1;
        chk("align_pc_id", PC_ID, 32'h100);
        chk("align_inst", inst_ID, inst_of(32'h100));
        chk("align_mis", {31'b0, misalign_ID}, 32'h0);
`endif

        drive(0,1,1,0,0,0,0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'b0, valid_ID}, 32'h0);
        chk("midrst_inst", inst_ID, NOP_I);
        chk("midrst_pc_id", PC_ID, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_mis", {31'b0, misalign_ID}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst_req", {31'b0, imem_req}, 32'h1);
        chk("postrst_addr", imem_addr, 32'h0);

        m_pc = 0; m_addr = 0; m_stale = 0;
        m_id_pc = 0; m_id_inst = NOP_I; m_id_valid = 0;
        fq.delete();
        for (int n = 0; n < 3000; n++) begin
            a = ($urandom % 3) != 0;
            e = ($urandom % 8) != 0;
            p = ($urandom % 8) != 0;
            s = ($urandom % 5) == 0;
            f = ($urandom % 10) == 0;
            b = ($urandom % 7) == 0;
            t = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 + ($urandom % 4) * 4) : ($urandom & 32'hFFFF_FFFC);
            drive(a, e, p, s, f, b, t);
            #1;
            chk("rnd_req", {31'b0, imem_req}, {31'b0, fq.size() == 0});
            if (fq.size() == 0) chk("rnd_addr", imem_addr, m_addr);

            adv = e & p & ~s;
            got = 0; gpc = 0; ginst = 0;
            if (fq.size() != 0) begin
                if (b) begin
                    fq.delete(); m_pc = t; m_addr = t;
                end else if (adv) begin
                    got = 1; gpc = fq[0].pc; ginst = fq[0].inst;
                    fq.delete(); m_pc = m_pc + 4; m_addr = m_pc;
                end
            end else if (m_stale) begin
                if (b) m_pc = t;
                if (a) begin m_stale = 0; m_addr = m_pc; end
            end else begin
                if (b) begin
                    m_pc = t;
                    if (a) m_addr = t; else m_stale = 1;
                end else if (a) begin
                    if (adv) begin
                        got = 1; gpc = m_pc; ginst = inst_of(m_addr);
                        m_pc = m_pc + 4; m_addr = m_pc;
                    end else begin
                        fq.push_back('{pc: m_pc, inst: inst_of(m_addr)});
                    end
                end
            end
            if (f) begin
                m_id_valid = 0; m_id_inst = NOP_I;
            end else if (e && !s) begin
                if (got) begin
                    m_id_valid = 1; m_id_inst = ginst; m_id_pc = gpc;
                end else begin
                    m_id_valid = 0; m_id_inst = NOP_I;
                end
            end

            @(posedge clk); #1;
            chk("rnd_pc_id", PC_ID, m_id_pc);
            chk("rnd_inst", inst_ID, m_id_inst);
            chk("rnd_valid", {31'b0, valid_ID}, {31'b0, m_id_valid});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
